// File: rtl/jtkunio_scr_rom.sv
// Scroll-layer ROM slot: fetches two 16-bit SDRAM words into one cached 32-bit line.
// Optional macro JTKUNIO_SCR_ABORT_EN restarts a fetch when the address moves during beat 0.
module jtkunio_scr_rom #(
  parameter int unsigned AW = 17
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          rom_cs,
  input  logic [AW-1:0] rom_addr,
  output logic [31:0]   rom_data,
  output logic          rom_ok,
  output logic [AW-1:0] sdram_addr,
  output logic          sdram_req,
  input  logic          sdram_ack,
  input  logic          data_rdy,
  input  logic [15:0]   sdram_din
);

  localparam int unsigned TW = AW - 1;

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] REQ0  = 3'd1;
  localparam logic [2:0] WAIT0 = 3'd2;
  localparam logic [2:0] REQ1  = 3'd3;
  localparam logic [2:0] WAIT1 = 3'd4;

  logic [2:0]    state, state_nxt;
  logic [TW-1:0] tag, tag_nxt;
  logic [TW-1:0] pend, pend_nxt;
  logic          valid, valid_nxt;
  logic [31:0]   data_nxt;
  logic          req_nxt;
  logic [AW-1:0] addr_nxt;
  logic [TW-1:0] line;
  logic          abort;
  logic          unused_bit0;

  assign line        = rom_addr[AW-1:1];
  assign unused_bit0 = rom_addr[0];
  assign rom_ok      = rom_cs & valid & (tag == line);

`ifdef JTKUNIO_SCR_ABORT_EN
  assign abort = rom_cs & (line != pend);
`else
  assign abort = 1'b0;
`endif

  // Next-state and registered-output logic
  always_comb begin
    state_nxt = state;
    tag_nxt   = tag;
    pend_nxt  = pend;
    valid_nxt = valid;
    data_nxt  = rom_data;
    req_nxt   = sdram_req;
    addr_nxt  = sdram_addr;
    case (state)
      IDLE: begin
        if (rom_cs && !rom_ok) begin
          pend_nxt  = line;
          valid_nxt = 1'b0;
          req_nxt   = 1'b1;
          addr_nxt  = {line, 1'b0};
          state_nxt = REQ0;
        end
      end
      REQ0: begin
        if (sdram_ack) begin
          req_nxt   = 1'b0;
          state_nxt = WAIT0;
        end
      end
      WAIT0: begin
        if (data_rdy) begin
          req_nxt = 1'b1;
          if (abort) begin
            // Beat 0 belongs to a stale line: drop it and restart on the new one
            pend_nxt  = line;
            addr_nxt  = {line, 1'b0};
            state_nxt = REQ0;
          end else begin
            data_nxt[15:0] = sdram_din;
            addr_nxt       = {pend, 1'b1};
            state_nxt      = REQ1;
          end
        end
      end
      REQ1: begin
        if (sdram_ack) begin
          req_nxt   = 1'b0;
          state_nxt = WAIT1;
        end
      end
      WAIT1: begin
        if (data_rdy) begin
          data_nxt[31:16] = sdram_din;
          tag_nxt         = pend;
          valid_nxt       = 1'b1;
          state_nxt       = IDLE;
        end
      end
      default: begin
        req_nxt   = 1'b0;
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      tag        <= '0;
      pend       <= '0;
      valid      <= 1'b0;
      rom_data   <= '0;
      sdram_req  <= 1'b0;
      sdram_addr <= '0;
    end else begin
      state      <= state_nxt;
      tag        <= tag_nxt;
      pend       <= pend_nxt;
      valid      <= valid_nxt;
      rom_data   <= data_nxt;
      sdram_req  <= req_nxt;
      sdram_addr <= addr_nxt;
    end
  end

endmodule

// File: tb/tb_jtkunio_scr_rom.sv
// Bench for jtkunio_scr_rom: SDRAM responder plus a line-level reference model of the cache.
// Honours JTKUNIO_SCR_ABORT_EN when the design is built with it.
module tb_jtkunio_scr_rom;
  localparam int unsigned AW = 17;

  logic          clk = 1'b0;
  logic          rst;
  logic          rom_cs;
  logic [AW-1:0] rom_addr;
  logic [31:0]   rom_data;
  logic          rom_ok;
  logic [AW-1:0] sdram_addr;
  logic          sdram_req;
  logic          sdram_ack;
  logic          data_rdy;
  logic [15:0]   sdram_din;

  int vectors     = 0;
  int miscompares = 0;
  int ack_delay   = 0;
  int rdy_delay   = 0;
  int stray_req   = 0;
  int stray_done  = 0;
  logic [AW-1:0] req_log[$];

  always #5 clk = ~clk;

  jtkunio_scr_rom #(.AW(AW)) dut (
    .clk(clk), .rst(rst), .rom_cs(rom_cs), .rom_addr(rom_addr),
    .rom_data(rom_data), .rom_ok(rom_ok), .sdram_addr(sdram_addr),
    .sdram_req(sdram_req), .sdram_ack(sdram_ack), .data_rdy(data_rdy),
    .sdram_din(sdram_din)
  );

  function automatic logic [15:0] mem_word(input logic [AW-1:0] a);
    if (a == 17'h00A40) return 16'h1234;
    if (a == 17'h00A41) return 16'hABCD;
    return 16'((32'(a) * 32'd40503) ^ 32'h5A5A);
  endfunction

  function automatic logic [31:0] line_of(input logic [AW-1:0] a);
    logic [AW-1:0] lo;
    lo = {a[AW-1:1], 1'b0};
    return {mem_word(lo | 17'd1), mem_word(lo)};
  endfunction

  // SDRAM slot model: acks after ack_delay cycles, returns data rdy_delay cycles after ack
  initial begin
    logic busy;
    int rwait, await_n;
    logic [AW-1:0] la;
    busy = 1'b0; rwait = 0; await_n = 0; la = '0;
    sdram_ack = 1'b0; data_rdy = 1'b0; sdram_din = '0;
    forever begin
      @(posedge clk); #1;
      sdram_ack = 1'b0;
      data_rdy  = 1'b0;
      if (rst) begin
        busy = 1'b0; await_n = 0;
      end else if (stray_req != stray_done) begin
        data_rdy = 1'b1; sdram_din = 16'hDEAD; stray_done++;
      end else if (busy) begin
        if (rwait == 0) begin
          data_rdy = 1'b1; sdram_din = mem_word(la); busy = 1'b0;
        end else rwait--;
      end else if (sdram_req) begin
        if (await_n < ack_delay) await_n++;
        else begin
          sdram_ack = 1'b1; la = sdram_addr; req_log.push_back(sdram_addr);
          busy = 1'b1; rwait = rdy_delay; await_n = 0;
        end
      end
    end
  end

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic wait_ok(output int cycles);
    cycles = 0;
    while (cycles < 300) begin
      @(negedge clk);
      if (rom_ok === 1'b1) break;
      cycles++;
    end
  endtask

  task automatic wait_log(input int n, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (req_log.size() >= n) begin ok = 1'b1; break; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; rom_cs = 1'b0; rom_addr = '0;
    step(); step();
    @(negedge clk);
    vectors++;
    if ({rom_ok, sdram_req, sdram_addr, rom_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_vals: ok=%b req=%b addr=%h data=%h required all zero",
               rom_ok, sdram_req, sdram_addr, rom_data);
    end
    step(); rst = 1'b0;
    step(); rom_cs = 1'b1; rom_addr = '0;
    rst = 1'b1; step(); rst = 1'b0; rom_cs = 1'b0;
  endtask

  task automatic test_basic();
    int c;
    ack_delay = 0; rdy_delay = 0;
    step(); req_log.delete();
    rom_cs = 1'b1; rom_addr = 17'h00A40;
    wait_ok(c);
    vectors++;
    if (c != 5) begin miscompares++; $display("FAIL basic_latency: got %0d cycles required 5", c); end
    vectors++;
    if (rom_data !== 32'hABCD1234) begin
      miscompares++; $display("FAIL basic_data: got %h required ABCD1234", rom_data);
    end
    vectors++;
    if (req_log.size() != 2 || req_log[0] !== 17'h00A40 || req_log[1] !== 17'h00A41) begin
      miscompares++;
      $display("FAIL basic_addrs: got %0d reqs first %h required 00A40,00A41", req_log.size(),
               req_log.size() > 0 ? req_log[0] : 17'h0);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 20; i++) begin
      step(); @(negedge clk);
      vectors++;
      if (rom_ok !== 1'b1 || sdram_req !== 1'b0) begin
        miscompares++; $display("FAIL hold_%0d: ok=%b req=%b required ok=1 req=0", i, rom_ok, sdram_req);
      end
    end
    vectors++;
    if (req_log.size() != 2) begin
      miscompares++; $display("FAIL hold_traffic: got %0d reqs required 2", req_log.size());
    end
  endtask

  task automatic test_top();
    int c;
    step(); req_log.delete();
    rom_addr = 17'h1FFFE;
    @(negedge clk);
    vectors++;
    if (rom_ok !== 1'b0) begin miscompares++; $display("FAIL top_drop: got ok=%b required 0", rom_ok); end
    wait_ok(c);
    vectors++;
    if (c >= 300 || rom_data !== line_of(17'h1FFFE)) begin
      miscompares++; $display("FAIL top_data: got %h required %h", rom_data, line_of(17'h1FFFE));
    end
    vectors++;
    if (req_log.size() != 2 || req_log[0] !== 17'h1FFFE || req_log[1] !== 17'h1FFFF) begin
      miscompares++;
      $display("FAIL top_addrs: got %0d reqs second %h required 1FFFE,1FFFF", req_log.size(),
               req_log.size() > 1 ? req_log[1] : 17'h0);
    end
  endtask

  task automatic test_ack_delay();
    bit active;
    int high, cyc;
    logic [AW-1:0] first;
    ack_delay = 7; active = 1'b0; high = 0; cyc = 0; first = '0;
    step(); req_log.delete();
    rom_addr = 17'h05550;
    while (cyc < 400) begin
      @(negedge clk);
      if (rom_ok === 1'b1) break;
      if (sdram_req === 1'b1) begin
        high++;
        if (!active) begin active = 1'b1; first = sdram_addr; end
        else begin
          vectors++;
          if (sdram_addr !== first) begin
            miscompares++; $display("FAIL ackdly_stable: got %h required %h", sdram_addr, first);
          end
        end
      end else active = 1'b0;
      cyc++;
    end
    vectors++;
    if (high != 16) begin miscompares++; $display("FAIL ackdly_req_cycles: got %0d required 16", high); end
    vectors++;
    if (req_log.size() != 2 || rom_data !== line_of(17'h05550)) begin
      miscompares++;
      $display("FAIL ackdly_line: got %0d acks data %h required 2 acks data %h",
               req_log.size(), rom_data, line_of(17'h05550));
    end
    ack_delay = 0;
  endtask

  task automatic test_abort();
    int c;
    bit ok;
    logic [AW-1:0] exp[$];
    rdy_delay = 3;
    step(); req_log.delete();
    rom_addr = 17'h00100;
    wait_log(1, ok);
    step(); rom_addr = 17'h00200;
    wait_ok(c);
`ifdef JTKUNIO_SCR_ABORT_EN
    exp = '{17'h00100, 17'h00200, 17'h00201};
`else
    exp = '{17'h00100, 17'h00101, 17'h00200, 17'h00201};
`endif
    vectors++;
    if (!ok || c >= 300 || rom_data !== line_of(17'h00200)) begin
      miscompares++; $display("FAIL abort_data: got %h required %h", rom_data, line_of(17'h00200));
    end
    vectors++;
    if (req_log.size() != exp.size()) begin
      miscompares++; $display("FAIL abort_count: got %0d reqs required %0d", req_log.size(), exp.size());
    end else begin
      for (int i = 0; i < exp.size(); i++) begin
        vectors++;
        if (req_log[i] !== exp[i]) begin
          miscompares++; $display("FAIL abort_addr%0d: got %h required %h", i, req_log[i], exp[i]);
        end
      end
    end
    rdy_delay = 0;
  endtask

  task automatic test_reset_midfetch();
    int c;
    bit ok;
    rdy_delay = 5;
    step(); req_log.delete();
    rom_addr = 17'h03330;
    wait_log(2, ok);
    step(); rst = 1'b1;
    step(); step(); rom_cs = 1'b0;
    step(); rst = 1'b0;
    step(); stray_req++;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (sdram_req !== 1'b0 || rom_data !== 32'h0 || rom_ok !== 1'b0) begin
        miscompares++;
        $display("FAIL rst_stray_%0d: req=%b data=%h ok=%b required 0/0/0", i, sdram_req, rom_data, rom_ok);
      end
      step();
    end
    rdy_delay = 0; req_log.delete();
    rom_cs = 1'b1;
    @(negedge clk);
    vectors++;
    if (!ok || rom_ok !== 1'b0) begin miscompares++; $display("FAIL rst_valid: got ok=%b required 0", rom_ok); end
    wait_ok(c);
    vectors++;
    if (c >= 300 || rom_data !== line_of(17'h03330) || req_log.size() != 2 || req_log[0] !== 17'h03330) begin
      miscompares++;
      $display("FAIL rst_refetch: got data %h reqs %0d required %h and 2", rom_data, req_log.size(),
               line_of(17'h03330));
    end
  endtask

  task automatic test_random();
    logic [AW-1:0] last, a;
    int c, r, n;
    last = 17'h03330;
    for (int it = 0; it < 30; it++) begin
      ack_delay = int'($urandom_range(0, 3));
      rdy_delay = int'($urandom_range(0, 3));
      r = int'($urandom_range(0, 3));
      step();
      if (r == 0) begin
        rom_cs = 1'b1; rom_addr = last; n = req_log.size();
        @(negedge clk);
        vectors++;
        if (rom_ok !== 1'b1 || rom_data !== line_of(last)) begin
          miscompares++; $display("FAIL rnd_hit_%0d: ok=%b data=%h required 1 %h", it, rom_ok, rom_data, line_of(last));
        end
        repeat (3) step();
        vectors++;
        if (req_log.size() != n) begin miscompares++; $display("FAIL rnd_hit_traffic_%0d: got %0d new reqs required 0", it, req_log.size() - n); end
      end else if (r == 1) begin
        rom_cs = 1'b0; rom_addr = AW'($urandom) & ~17'd1;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          vectors++;
          if (rom_ok !== 1'b0 || sdram_req !== 1'b0) begin
            miscompares++; $display("FAIL rnd_idle_%0d: ok=%b req=%b required 0/0", it, rom_ok, sdram_req);
          end
          step();
        end
      end else begin
        do a = AW'($urandom) & ~17'd1; while (a == last);
        req_log.delete();
        rom_cs = 1'b1; rom_addr = a;
        wait_ok(c);
        vectors++;
        if (c >= 300 || rom_data !== line_of(a) || req_log.size() != 2 ||
            req_log[0] !== a || req_log[1] !== (a | 17'd1)) begin
          miscompares++;
          $display("FAIL rnd_miss_%0d: addr %h data %h reqs %0d required %h and 2", it, a, rom_data,
                   req_log.size(), line_of(a));
        end
        last = a;
      end
    end
    ack_delay = 0; rdy_delay = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_top();
    test_ack_delay();
    test_abort();
    test_reset_midfetch();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
